// File: rtl/oc8051_xrom_resp_if.sv
// rtl/oc8051_xrom_resp_if.sv - fetch and code-memory bus bundle for oc8051_xrom_resp
//
// Purpose: groups the core fetch handshake and the byte-wide code-memory
// port of the external-ROM responder.
// Modports:
//   slave  - the responder (oc8051_xrom_resp)
//   master - the core side plus code memory (drives requests and read data)
// Signals:
//   istb_i     fetch request, level, held until iack_o
//   iadr_i     16-bit code address of op1
//   iack_o     one-cycle fetch-complete pulse
//   op1_o..3_o fetched bytes at adr, adr+1, adr+2
//   err_o      high with iack_o when a byte of the fetch timed out
//   mem_rd_o   memory read request
//   mem_adr_o  memory byte address
//   mem_dat_i  memory read data, valid with mem_rdy_i
//   mem_rdy_i  memory ready
interface oc8051_xrom_resp_if;
  logic        istb_i;
  logic [15:0] iadr_i;
  logic        iack_o;
  logic [7:0]  op1_o;
  logic [7:0]  op2_o;
  logic [7:0]  op3_o;
  logic        err_o;
  logic        mem_rd_o;
  logic [15:0] mem_adr_o;
  logic [7:0]  mem_dat_i;
  logic        mem_rdy_i;

  modport slave (
    input  istb_i, iadr_i, mem_dat_i, mem_rdy_i,
    output iack_o, op1_o, op2_o, op3_o, err_o, mem_rd_o, mem_adr_o
  );

  modport master (
    output istb_i, iadr_i, mem_dat_i, mem_rdy_i,
    input  iack_o, op1_o, op2_o, op3_o, err_o, mem_rd_o, mem_adr_o
  );
endinterface

// File: rtl/oc8051_xrom_resp.sv
// rtl/oc8051_xrom_resp.sv - 8051 external program-memory fetch responder
//
// Purpose: accepts an instruction fetch from the core, reads three
// consecutive bytes from byte-wide code memory and returns them as
// op1/op2/op3 with a one-cycle acknowledge. A byte that is not delivered
// within TIMEOUT wait cycles is replaced by 8'h00 (NOP) and flagged on err_o.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   io_xrom  oc8051_xrom_resp_if.slave (fetch handshake + memory port)
// Parameters:
//   TIMEOUT  wait cycles per byte before substitution (1..255)
// Optional feature macro: OC8051_XROM_HIT_EN
//   When defined, a one-entry buffer remembers the base address of the last
//   error-free fetch; a repeat request to it acknowledges without memory reads.
module oc8051_xrom_resp #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  oc8051_xrom_resp_if.slave      io_xrom
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_RD3, S_ACK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_base;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [7:0]  r_op1;
  logic [7:0]  r_op2;
  logic [7:0]  r_op3;
  logic        w_rd;
  logic        w_abort;
  logic        w_xfer;
  logic        w_tmo;
  logic        w_hit;
  logic        w_accept;
  logic [15:0] w_adr;
  logic [7:0]  w_byte;

  assign w_rd     = (r_state == S_RD1) || (r_state == S_RD2) || (r_state == S_RD3);
  // Abort wins over both transfer and timeout in the same cycle.
  assign w_abort  = w_rd && !io_xrom.istb_i;
  assign w_xfer   = w_rd && io_xrom.istb_i && io_xrom.mem_rdy_i;
  assign w_tmo    = w_rd && io_xrom.istb_i && !io_xrom.mem_rdy_i && (r_cnt == TMO);
  assign w_accept = (r_state == S_IDLE) && io_xrom.istb_i;
  // Timed-out bytes become NOP.
  assign w_byte   = w_xfer ? io_xrom.mem_dat_i : 8'h00;

`ifdef OC8051_XROM_HIT_EN
  logic r_hit_vld;

  assign w_hit = r_hit_vld && (io_xrom.iadr_i == r_base);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_vld <= 1'b0;
    end else if (w_accept && !w_hit) begin
      // r_base is about to be overwritten; the entry only becomes valid
      // again once this new fetch completes cleanly.
      r_hit_vld <= 1'b0;
    end else if (w_abort || w_tmo) begin
      r_hit_vld <= 1'b0;
    end else if ((r_state == S_ACK) && !r_err) begin
      r_hit_vld <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_adr  = 16'h0000;
    case (r_state)
      S_IDLE: begin
        if (io_xrom.istb_i) w_next = w_hit ? S_ACK : S_RD1;
      end
      S_RD1: begin
        w_adr = r_base;
        if (w_abort)              w_next = S_IDLE;
        else if (w_xfer || w_tmo) w_next = S_RD2;
      end
      S_RD2: begin
        w_adr = r_base + 16'd1;
        if (w_abort)              w_next = S_IDLE;
        else if (w_xfer || w_tmo) w_next = S_RD3;
      end
      S_RD3: begin
        w_adr = r_base + 16'd2;
        if (w_abort)              w_next = S_IDLE;
        else if (w_xfer || w_tmo) w_next = S_ACK;
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= 16'h0000;
      r_cnt   <= 8'h00;
      r_err   <= 1'b0;
      r_op1   <= 8'h00;
      r_op2   <= 8'h00;
      r_op3   <= 8'h00;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_base <= io_xrom.iadr_i;
        r_err  <= 1'b0;
      end else if (w_tmo) begin
        r_err  <= 1'b1;
      end

      if (w_xfer || w_tmo || w_abort) r_cnt <= 8'h00;
      else if (w_rd)                  r_cnt <= r_cnt + 8'd1;

      if (w_xfer || w_tmo) begin
        case (r_state)
          S_RD1:   r_op1 <= w_byte;
          S_RD2:   r_op2 <= w_byte;
          S_RD3:   r_op3 <= w_byte;
          default: ;
        endcase
      end
    end
  end

  assign io_xrom.iack_o    = (r_state == S_ACK);
  assign io_xrom.err_o     = (r_state == S_ACK) && r_err;
  assign io_xrom.mem_rd_o  = w_rd;
  assign io_xrom.mem_adr_o = w_adr;
  assign io_xrom.op1_o     = r_op1;
  assign io_xrom.op2_o     = r_op2;
  assign io_xrom.op3_o     = r_op3;

endmodule

// File: tb/tb_oc8051_xrom_resp.sv
// tb/tb_oc8051_xrom_resp.sv - self-checking bench for oc8051_xrom_resp
module tb_oc8051_xrom_resp;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  oc8051_xrom_resp_if xif ();

  oc8051_xrom_resp #(.TIMEOUT(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_xrom (xif.slave)
  );

`ifdef OC8051_XROM_HIT_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_RD  = 0;
  localparam int HIT_XF  = 0;
`else
  localparam int HIT_LAT = 4;
  localparam int HIT_RD  = 3;
  localparam int HIT_XF  = 3;
`endif

  typedef struct packed {
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] o3;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mem_waits = 0;
  int   mcnt = 0;
  logic prev_iack = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [15:0] a);
    case (a)
      16'h0100: byte_at = 8'h12;
      16'h0101: byte_at = 8'h02;
      16'h0102: byte_at = 8'h34;
      default:  byte_at = a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  // Code memory: ready after mem_waits wait cycles per byte, garbage data otherwise.
  always @(negedge clk) begin
    if (xif.mem_rd_o !== 1'b1) begin
      mcnt          = 0;
      xif.mem_rdy_i = 1'b0;
      xif.mem_dat_i = 8'hEE;
    end else if (mcnt >= mem_waits) begin
      mcnt          = 0;
      xif.mem_rdy_i = 1'b1;
      xif.mem_dat_i = byte_at(xif.mem_adr_o);
    end else begin
      mcnt          = mcnt + 1;
      xif.mem_rdy_i = 1'b0;
      xif.mem_dat_i = 8'hEE;
    end
  end

  // Scoreboard consumer: every iack_o pops one expected fetch result.
  always begin
    @(negedge clk);
    #1;
    if (!rst && xif.iack_o) begin
      if (prev_iack) check_val("iack_back_to_back", 32'd1, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_iack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("op1", {24'h0, xif.op1_o}, {24'h0, e.o1});
        check_val("op2", {24'h0, xif.op2_o}, {24'h0, e.o2});
        check_val("op3", {24'h0, xif.op3_o}, {24'h0, e.o3});
        check_val("err", {31'h0, xif.err_o}, {31'h0, e.err});
      end
    end
    prev_iack = xif.iack_o;
  end

  task automatic do_fetch(input logic [15:0] adr, input int waits, input int exp_lat,
                          input int exp_rd, input int exp_xf, input exp_t e);
    int  rd_cyc = 0;
    int  xf = 0;
    bit  done = 0;
    @(negedge clk);
    #1;
    mem_waits   = waits;
    xif.istb_i  = 1'b1;
    xif.iadr_i  = adr;
    sb_q.push_back(e);
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      #1;
      if (xif.mem_rd_o) rd_cyc++;
      if (xif.mem_rd_o && xif.mem_rdy_i) begin
        check_val("mem_adr", {16'h0, xif.mem_adr_o}, {16'h0, adr + 16'(xf)});
        xf++;
      end
      if (xif.iack_o) begin
        check_val("latency", cyc, exp_lat);
        check_val("rd_cycles", rd_cyc, exp_rd);
        check_val("transfers", xf, exp_xf);
        xif.istb_i = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      check_val("iack_wait", 32'd0, 32'd1);
      xif.istb_i = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    rst        = 1'b1;
    xif.istb_i = 1'b0;
    xif.iadr_i = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_iack", {31'h0, xif.iack_o}, 32'd0);
    check_val("rst_err",  {31'h0, xif.err_o}, 32'd0);
    check_val("rst_rd",   {31'h0, xif.mem_rd_o}, 32'd0);
    check_val("rst_adr",  {16'h0, xif.mem_adr_o}, 32'd0);
    check_val("rst_ops",  {8'h0, xif.op1_o, xif.op2_o, xif.op3_o}, 32'd0);

    // Zero-wait fetch.
    e = '{8'h12, 8'h02, 8'h34, 1'b0};
    do_fetch(16'h0100, 0, 4, 3, 3, e);

    // Address wrap with two wait cycles per byte.
    e = '{byte_at(16'hFFFF), byte_at(16'h0000), byte_at(16'h0001), 1'b0};
    do_fetch(16'hFFFF, 2, 10, 9, 3, e);

    // Memory never ready: every byte times out.
    e = '{8'h00, 8'h00, 8'h00, 1'b1};
    do_fetch(16'h1234, 100000, 49, 48, 0, e);

    // Abort during RD2 (memory ready in that cycle, abort must win).
    @(negedge clk);
    #1;
    mem_waits  = 0;
    xif.istb_i = 1'b1;
    xif.iadr_i = 16'h0200;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_val("abort_rd2_adr", {16'h0, xif.mem_adr_o}, 32'h0201);
    xif.istb_i = 1'b0;
    @(negedge clk); #1;
    check_val("abort_rd_low", {31'h0, xif.mem_rd_o}, 32'd0);
    check_val("abort_op1", {24'h0, xif.op1_o}, {24'h0, byte_at(16'h0200)});
    check_val("abort_op2", {24'h0, xif.op2_o}, 32'h00);
    repeat (3) begin
      @(negedge clk); #1;
      check_val("abort_no_iack", {31'h0, xif.iack_o}, 32'd0);
    end

    e = '{byte_at(16'h0200), byte_at(16'h0201), byte_at(16'h0202), 1'b0};
    do_fetch(16'h0200, 0, 4, 3, 3, e);

    // Back-to-back fetches to the same address.
    e = '{byte_at(16'h0040), byte_at(16'h0041), byte_at(16'h0042), 1'b0};
    do_fetch(16'h0040, 0, 4, 3, 3, e);
    do_fetch(16'h0040, 0, HIT_LAT, HIT_RD, HIT_XF, e);

    // Asynchronous reset during RD3.
    @(negedge clk);
    #1;
    mem_waits  = 0;
    xif.istb_i = 1'b1;
    xif.iadr_i = 16'h0300;
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_val("rd3_adr", {16'h0, xif.mem_adr_o}, 32'h0302);
    rst = 1'b1;
    #1;
    check_val("arst_rd",   {31'h0, xif.mem_rd_o}, 32'd0);
    check_val("arst_adr",  {16'h0, xif.mem_adr_o}, 32'd0);
    check_val("arst_iack", {31'h0, xif.iack_o}, 32'd0);
    check_val("arst_ops",  {8'h0, xif.op1_o, xif.op2_o, xif.op3_o}, 32'd0);
    #1;
    rst        = 1'b0;
    xif.istb_i = 1'b0;

    e = '{byte_at(16'h0300), byte_at(16'h0301), byte_at(16'h0302), 1'b0};
    do_fetch(16'h0300, 1, 7, 6, 3, e);

    repeat (3) @(negedge clk);
    #2;
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oc8051_xrom_resp.md
# oc8051_xrom_resp

External program-memory responder for the 8051 core's instruction fetch handshake. Accepts a fetch strobe and a 16-bit code address from the core and reads three consecutive bytes from a byte-wide external code memory. It then returns them as op1/op2/op3 with a one-cycle acknowledge. It sits between the core's external-ROM port (istb/iack, op1_x/op2_x/op3_x) and the board-level code memory.

## Interface
Parameters:
- TIMEOUT, 15: maximum wait cycles per memory byte before substitution; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- istb_i  in  1  fetch request from the core; level, held until iack_o.
- iadr_i  in  16  code address of op1; sampled only when a request is accepted.
- iack_o  out  1  one-cycle fetch-complete pulse.
- op1_o, op2_o, op3_o  out  8 each  bytes at adr, adr+1, adr+2; hold last values between fetches.
- err_o  out  1  high together with iack_o when any byte of that fetch timed out.
- mem_rd_o  out  1  memory read request.
- mem_adr_o  out  16  memory byte address.
- mem_dat_i  in  8  memory read data; valid in cycles where mem_rdy_i=1.
- mem_rdy_i  in  1  memory ready; a byte transfer completes in any cycle with mem_rd_o=1 and mem_rdy_i=1.

## Operation
- Reset values: iack_o=0, err_o=0, mem_rd_o=0, mem_adr_o=16'h0000, op1_o/op2_o/op3_o=8'h00. FSM goes to IDLE, wait counter=0, error flag=0, hit buffer invalid.
- FSM states: IDLE, RD1, RD2, RD3, ACK.
- IDLE:
  - istb_i=1 -> latch iadr_i into the base address, clear the error flag, go to RD1.
  - iadr_i is ignored after acceptance.
- RDn (n=1..3):
  - mem_rd_o=1; mem_adr_o = base + (n-1), computed modulo 2^16 (16'hFFFF+1 wraps to 16'h0000).
  - On a transfer, mem_dat_i is captured into opn_o, the counter is cleared, and the FSM advances (RD3 advances to ACK).
  - Each cycle without mem_rdy_i increments the counter.
  - When the counter reaches TIMEOUT with mem_rdy_i still low, opn_o <= 8'h00 (NOP), the error flag is set, the counter is cleared, and the FSM advances.
- ACK:
  - iack_o=1, err_o = error flag, mem_rd_o=0; next state is IDLE.
- Abort: istb_i=0 in any RDn -> next state IDLE, mem_rd_o drops at that edge, no iack_o, and the hit buffer is invalidated. Bytes captured so far remain on the op outputs.
- Priority: abort overrides both transfer and timeout in the same cycle.
- istb_i still high in the IDLE cycle after ACK starts a new fetch at the current iadr_i.
- op outputs change only on capture or substitution, never in IDLE or ACK.

## Timing
- Zero-wait memory (mem_rdy_i tied high):
  - istb_i accepted at edge 0.
  - RD1/RD2/RD3 occupy cycles 1/2/3.
  - iack_o high in cycle 4; op outputs stable from the end of cycle 3.
- Each wait cycle on a byte adds one cycle of latency.
- Worst case per fetch: 3*(TIMEOUT+1)+1 cycles after acceptance.
- iack_o is never high for two consecutive cycles. Minimum spacing between iack_o pulses: 5 cycles without the hit feature.
- Reset is asynchronous and has effect mid-fetch: outputs return to reset values immediately, with no iack_o.

## Configuration
- OC8051_XROM_HIT_EN defined:
  - A one-entry buffer (base address plus valid bit) is set on every completed fetch with err_o=0.
  - In IDLE, istb_i=1 with valid buffer and iadr_i == stored address -> go directly to ACK. iack_o then fires 1 cycle after acceptance, with no memory access and op outputs unchanged.
  - Abort, timeout, or reset invalidates the buffer.
- OC8051_XROM_HIT_EN undefined: no buffer; every request performs three memory reads.

## Test plan
- Zero-wait fetch at 16'h0100, memory bytes 12/02/34 -> mem_adr_o 0100/0101/0102 in cycles 1-3, iack_o in cycle 4, op=12,02,34, err_o=0.
- Fetch at 16'hFFFF with 2 wait cycles per byte -> addresses FFFF, 0000, 0001; iack_o in cycle 10.
- mem_rdy_i stuck low, TIMEOUT=15 -> each byte takes 16 cycles, op=00,00,00, iack_o with err_o=1 in cycle 49.
- istb_i dropped during RD2 -> mem_rd_o low next cycle, no iack_o. Next fetch still performs three reads with the macro defined.
- Macro defined: two back-to-back fetches at 16'h0040 -> second iack_o 1 cycle after acceptance, mem_rd_o stays low. Macro undefined: second fetch takes 4 cycles.
- rst pulsed during RD3 -> all outputs at reset values asynchronously; the subsequent fetch completes normally.
